// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller: forwarding encodings,
// architectural register numbers and the per-stage scoreboard entry.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_EX  = 2'b10;

    localparam logic [4:0] XZR = 5'd31;
    localparam logic [4:0] LR  = 5'd30;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       writes;
        logic       is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dest: 5'd0, writes: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/hazard_ctrl_match.sv
// Compares one scoreboard entry against one ID source register.
// XZR never creates a dependency because it is hard-wired to zero.
module sb_entry_match
    import hazard_ctrl_pkg::*;
(
    input  sb_entry_t  entry,
    input  logic [4:0] src,
    output logic       match,
    output logic       match_load
);

    assign match      = entry.valid && entry.writes && (entry.dest == src) && (src != XZR);
    assign match_load = match && entry.is_load;

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: tracks in-flight destinations for EX/MEM/WB and
// decides stall, IF/ID flush and the CBZ/STUR early-forwarding selects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic [4:0]  id_rd,
    input  logic        id_reg2loc,
    input  logic        id_cbz,
    input  logic        id_stur,
    input  logic        id_ldur,
    input  logic        id_bl,
    input  logic        id_regwrite,
    input  logic        id_br_taken,
    output logic        stall,
    output logic        flush_ifid,
    output logic        forward_zero,
    output logic [1:0]  forward_store,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    sb_entry_t   ex_reg, mem_reg, wb_reg;
    sb_entry_t   id_entry;
    sb_entry_t   stage_entry [2];
    logic [4:0]  src_sel [2];
    logic [4:0]  src_a, src_b;
    logic [3:0]  hit, hit_load;
    logic        stall_raw, fwd_zero_raw;
    logic [1:0]  fwd_store_raw;
    logic [15:0] stall_cnt_reg, flush_cnt_reg;
    logic        wb_unused;

    assign src_a = id_cbz     ? id_rd : id_rn;
    assign src_b = id_reg2loc ? id_rm : id_rd;

    assign id_entry.valid   = id_valid;
    assign id_entry.dest    = id_bl ? LR : id_rd;
    assign id_entry.writes  = id_valid && (id_regwrite || id_bl);
    assign id_entry.is_load = id_ldur;

    assign stage_entry[0] = ex_reg;
    assign stage_entry[1] = mem_reg;
    assign src_sel[0]     = src_a;
    assign src_sel[1]     = src_b;

    // hit index = stage*2 + source: 0 EX/A, 1 EX/B, 2 MEM/A, 3 MEM/B
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_match
            sb_entry_match u_match (
                .entry      (stage_entry[gi / 2]),
                .src        (src_sel[gi % 2]),
                .match      (hit[gi]),
                .match_load (hit_load[gi])
            );
        end
    endgenerate

    // WB results reach the regfile before ID reads it, so WB never matters.
    assign wb_unused = ^wb_reg;

    always_comb begin
        stall_raw     = 1'b0;
        fwd_zero_raw  = 1'b0;
        fwd_store_raw = FWD_RF;
        if (id_valid) begin
            if (id_cbz) begin
                if (hit[0]) begin
                    if (hit_load[0]) stall_raw = 1'b1;
                    else             fwd_zero_raw = 1'b1;
                end else if (hit[2]) begin
                    stall_raw = 1'b1;
                end
            end
            if (id_stur) begin
                if (hit[1]) begin
                    if (hit_load[1]) stall_raw = 1'b1;
                    else             fwd_store_raw = FWD_EX;
                end else if (hit[3]) begin
                    if (hit_load[3]) stall_raw = 1'b1;
                    else             fwd_store_raw = FWD_MEM;
                end
                // The store base address still needs the ordinary load-use interlock.
                if (hit_load[0]) stall_raw = 1'b1;
            end
            if (!id_cbz && !id_stur && (hit_load[0] || hit_load[1])) begin
                stall_raw = 1'b1;
            end
        end
    end

    assign stall         = stall_raw;
    assign forward_zero  = fwd_zero_raw && !stall_raw;
    assign forward_store = stall_raw ? FWD_RF : fwd_store_raw;
    assign flush_ifid    = id_valid && id_br_taken && !stall_raw;
    assign stall_cnt     = stall_cnt_reg;
    assign flush_cnt     = flush_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_reg        <= SB_EMPTY;
            mem_reg       <= SB_EMPTY;
            wb_reg        <= SB_EMPTY;
            stall_cnt_reg <= 16'd0;
            flush_cnt_reg <= 16'd0;
        end else begin
            wb_reg  <= mem_reg;
            mem_reg <= ex_reg;
            ex_reg  <= stall_raw ? SB_EMPTY : id_entry;
            if (stall_raw && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            if (flush_ifid && (flush_cnt_reg != 16'hFFFF)) begin
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
            end
        end
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  input  1  single pipeline clock, rising-edge active.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 id_valid  input  1  ID stage holds a real instruction, not a bubble.
REQ-004 id_rn, id_rm, id_rd  input  5 each  ID-stage register fields.
REQ-005 id_reg2loc, id_cbz, id_stur, id_ldur, id_bl, id_regwrite  input  1 each  ID-stage decoded controls.
REQ-006 id_br_taken  input  1  branch (B/BL/taken CBZ) resolved taken in ID this cycle.
REQ-007 stall  output  1  hold PC and IF/ID; insert bubble into ID/EX.
REQ-008 flush_ifid  output  1  replace IF/ID contents with bubble at next edge.
REQ-009 forward_zero  output  1  drive EX ALU result onto Da for CBZ.
REQ-010 forward_store  output  2  Db source: 00 regfile, 01 MEM ALU result, 10 EX ALU result; 11 never driven.
REQ-011 stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-012 Sources: srcA = id_rd if id_cbz else id_rn; srcB = id_rm if id_reg2loc else id_rd.
REQ-013 ID destination = 30 if id_bl else id_rd; entry writes if id_valid and (id_regwrite or id_bl).
REQ-014 Scoreboard holds EX, MEM, WB entries {valid, dest[4:0], writes, is_load}, all registered.
REQ-015 Each edge: WB<=MEM, MEM<=EX; EX<=ID entry, or invalid entry when stall is 1.
REQ-016 Match(stage,src) = entry valid and writes and dest==src and src!=31.
REQ-017 CBZ srcA: EX match non-load -> forward_zero=1; EX match load -> stall; MEM match (any) -> stall.
REQ-018 STUR srcB: EX match non-load -> forward_store=10; MEM match non-load -> 01; EX or MEM match load -> stall.
REQ-019 EX match wins over MEM match for the same source.
REQ-020 Other instructions: EX-stage load matching srcA or srcB -> stall; otherwise no action.
REQ-021 WB matches need no action (regfile write-before-read).
REQ-022 stall, forward_zero, forward_store are combinational from ID inputs and registered scoreboard; all 0 when id_valid=0.
REQ-023 Resulting stall lengths: load-to-CBZ/STUR 2 cycles; ALU-to-CBZ in MEM 1 cycle; classic load-use 1 cycle.
REQ-024 forward_zero and forward_store forced 0 while stall=1.
REQ-025 flush_ifid = id_valid and id_br_taken and not stall; stall has priority.
REQ-026 stall_cnt increments each cycle stall=1, flush_cnt each cycle flush_ifid=1; both saturate at 16'hFFFF.

Reset
REQ-027 reset_n low: all scoreboard entries invalid, counters 0, immediately, independent of clk.
REQ-028 During and after reset until first valid ID: stall=0, flush_ifid=0, forward_zero=0, forward_store=00.
REQ-029 Reset mid-stall terminates stall on assertion; no pending stall cycles survive reset.

Structure
REQ-030 Shared package holds: forward_store encodings (FWD_RF, FWD_MEM, FWD_EX), XZR=31, LR=30, scoreboard entry struct.
REQ-031 One sub-module sb_entry_match (entry + source -> match, match_load) instantiated per stage/source.

Verification
REQ-032 ADD X1 then CBZ X1 next -> forward_zero=1, stall=0, stall_cnt unchanged.
REQ-033 LDUR X2 then STUR X2 next -> stall=1 for exactly 2 cycles, then forward_store=00, stall_cnt=2.
REQ-034 ADD X3, unrelated op, STUR X3 -> forward_store=01 on STUR in ID, no stall.
REQ-035 LDUR X31 then ADD using X31 -> no stall; BL then CBZ X30 -> forward_zero=1.
REQ-036 CBZ with id_br_taken=1 while stall=1 -> flush_ifid=0; after stall clears -> flush_ifid=1 one cycle, flush_cnt=1.
REQ-037 reset_n low during 2-cycle stall -> stall=0 same cycle, counters 0; force counter to 16'hFFFE, two more stalls -> 16'hFFFF.
